// File: rtl/sm_seq_ctrl_if.sv
// Request/step bus for sm_seq_ctrl: two requester handshakes plus the
// stepping-machine link (position in, a/b pulses out) and status flags.
interface sm_seq_ctrl_if;
  logic       req0_valid;
  logic [1:0] req0_target;
  logic       req0_ready;
  logic       req1_valid;
  logic [1:0] req1_target;
  logic       req1_ready;
  logic [1:0] state_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       err;
  logic       owner;

  // Environment side: requesters and the stepping machine.
  modport master (
    output req0_valid, req0_target, req1_valid, req1_target, state_in,
    input  req0_ready, req1_ready, a_out, b_out, busy, done, err, owner
  );

  // Controller side.
  modport slave (
    input  req0_valid, req0_target, req1_valid, req1_target, state_in,
    output req0_ready, req1_ready, a_out, b_out, busy, done, err, owner
  );
endinterface

// File: rtl/sm_seq_ctrl.sv
// Sequencing controller for the three-position a/b stepping machine.
// Arbitrates two requesters round-robin, issues one-cycle a (up) / b (down)
// pulses, waits SETTLE cycles after each, and re-reads the position until
// the target is reached (done) or the request is aborted (err).
module sm_seq_ctrl #(
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned MAX_STEPS = 4
) (
  input logic         clk,
  input logic         rst,
  sm_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_STEP,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] STEP_LIMIT  = 4'(MAX_STEPS);

  state_t     state;
  state_t     state_nx;
  logic [1:0] target;
  logic [3:0] step_cnt;
  logic [3:0] settle_cnt;
  logic       last;
  logic       owner_r;
  logic       a_r;
  logic       b_r;
  logic       grant0;
  logic       grant1;
  logic [1:0] sel_target;
  logic       step_up;

  // Position order 00 < 01 < 11; the illegal code 10 never reaches a compare.
  function automatic logic [1:0] rank(input logic [1:0] pos);
    case (pos)
      2'b00:   rank = 2'd0;
      2'b01:   rank = 2'd1;
      default: rank = 2'd2;
    endcase
  endfunction

  // Round-robin grant, only in IDLE and never while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_IDLE && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || last)) grant0 = 1'b1;
      else if (bus.req1_valid)                          grant1 = 1'b1;
    end
  end

  assign sel_target = grant1 ? bus.req1_target : bus.req0_target;

  // Next-state logic and step direction.
  always_comb begin
    state_nx = state;
    step_up  = (rank(bus.state_in) < rank(target));
    unique case (state)
      ST_IDLE: begin
        if (grant0 || grant1) state_nx = (sel_target == 2'b10) ? ST_ERR : ST_CHECK;
      end
      ST_CHECK: begin
        if (bus.state_in == 2'b10)       state_nx = ST_ERR;
        else if (bus.state_in == target) state_nx = ST_DONE;
        else if (step_cnt == STEP_LIMIT) state_nx = ST_ERR;
        else                             state_nx = ST_STEP;
      end
      ST_STEP:   state_nx = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = ST_CHECK;
      ST_DONE:   state_nx = ST_IDLE;
      ST_ERR:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Request latch, arbitration history, saturating counters and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= 1'b1;
      owner_r    <= 1'b0;
      target     <= '0;
      step_cnt   <= '0;
      settle_cnt <= '0;
      a_r        <= 1'b0;
      b_r        <= 1'b0;
    end else begin
      a_r <= (state_nx == ST_STEP) && step_up;
      b_r <= (state_nx == ST_STEP) && !step_up;
      if (grant0 || grant1) begin
        target   <= sel_target;
        owner_r  <= grant1;
        last     <= grant1;
        step_cnt <= '0;
      end else if (state == ST_STEP && step_cnt != '1) begin
        step_cnt <= step_cnt + 4'd1;
      end
      if (state == ST_STEP)                              settle_cnt <= '0;
      else if (state == ST_SETTLE && settle_cnt != '1) settle_cnt <= settle_cnt + 4'd1;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.a_out      = a_r;
  assign bus.b_out      = b_r;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.err        = (state == ST_ERR);
  assign bus.owner      = owner_r;

endmodule

// File: doc/sm_seq_ctrl.md
# sm_seq_ctrl

Sequencing controller for the three-position `a`/`b` stepping state machine. The positions are 2'b00, 2'b01 and 2'b11. The block accepts target positions from two requesters, with round-robin arbitration. It drives one-cycle `a` (step up) or `b` (step down) pulses into the state machine, waits a settle interval after each pulse, and re-reads the position. It reports `done` when the target is reached and `err` on illegal targets, illegal positions or a stuck machine. It sits between the command sources and the stepping machine, and is the only driver of that machine's `a` and `b` inputs.

## Interface
- SETTLE, 2: idle cycles after each pulse before re-reading position; legal range 1..15.
- MAX_STEPS, 4: pulses allowed per request before declaring a fault; legal range 1..15.

Ports:
- clk  input  1  clock; everything is rising-edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a target.
- req0_target  input  2  requester 0 target position.
- req0_ready  output  1  requester 0 target accepted this cycle; combinational.
- req1_valid  input  1  requester 1 has a target.
- req1_target  input  2  requester 1 target position.
- req1_ready  output  1  requester 1 target accepted this cycle; combinational.
- state_in  input  2  current position from the stepping machine.
- a_out  output  1  step-up pulse, registered.
- b_out  output  1  step-down pulse, registered.
- busy  output  1  a request is in progress.
- done  output  1  one-cycle pulse: target reached.
- err  output  1  one-cycle pulse: request aborted.
- owner  output  1  id of the requester currently or most recently served.

## Operation
- Position order: 2'b00 < 2'b01 < 2'b11; 2'b10 is illegal.
- FSM states: IDLE, CHECK, STEP, SETTLE, DONE, ERR.
- IDLE:
  - If any `valid` is high, grant one requester and assert its `ready` in this cycle; the transfer happens on that cycle.
  - Latch the target, set `owner`, clear the step counter.
  - Target 2'b10 → ERR; otherwise → CHECK.
- Arbitration:
  - With a single requester valid, that requester wins.
  - With both valid, the requester not granted last time wins.
  - `last` resets to 1, so req0 wins the first tie.
  - At most one `ready` is high in any cycle; `ready` is never high outside IDLE.
- CHECK:
  - `state_in` == 2'b10 → ERR.
  - `state_in` == target → DONE.
  - Step counter == MAX_STEPS → ERR.
  - Otherwise → STEP, with direction up if `state_in` < target, else down.
- STEP: exactly one of `a_out`/`b_out` is high for one cycle; counter increments; → SETTLE.
- SETTLE: wait SETTLE cycles with `a_out` = `b_out` = 0; → CHECK.
- DONE: `done` = 1 for one cycle; → IDLE.
- ERR: `err` = 1 for one cycle; → IDLE.
- `busy` = 1 in every state except IDLE.
- Requests arriving while busy are held off (`ready` = 0) and are not lost; each requester must hold `valid` and its target stable until `ready`.
- `a_out` and `b_out` are never high together, and never high outside STEP.
- Counters are 4 bits wide; they saturate and do not wrap.
- Reset (at any time, including mid-pulse or mid-settle):
  - FSM → IDLE, `last` = 1, counters = 0.
  - `a_out`, `b_out`, `busy`, `done`, `err`, `owner` = 0; both `ready` = 0 during reset.
  - The in-flight request is dropped without `done` or `err`.

## Timing
- Request accepted in cycle T.
- Already at target: CHECK at T+1, `done` at T+2.
- Illegal target: `err` at T+1.
- One step: CHECK T+1; pulse T+2; SETTLE T+3..T+2+SETTLE; CHECK T+3+SETTLE; `done` T+4+SETTLE. With SETTLE = 2, `done` is at T+6.
- Each additional step adds 2+SETTLE cycles.
- `done`/`err` cycle is followed by IDLE, so the earliest next accept is one cycle after the `done`/`err` cycle.
- The stepping machine must present its updated position within SETTLE cycles of the pulse.

## Test plan
- Zero-step request: reset, `state_in` = 00, req0 target 00 → `req0_ready` at T, no pulse, `done` at T+2, `owner` = 0.
- Two steps up then down:
  - Bench model of the stepping machine, SETTLE = 2.
  - req1 target 11 from 00 → `a_out` pulses at T+2 and T+6, `done` at T+10.
  - Then req1 target 00 → two `b_out` pulses, `done`.
- Tie arbitration: both valid from reset → req0 granted first, req1 granted next, req0 next; no cycle has both `ready` high.
- Errors:
  - Target 2'b10 → `err` at T+1, no pulse.
  - Model stuck at 00 with target 01, MAX_STEPS = 4 → 4 `a_out` pulses, then `err`.
  - `state_in` forced to 10 → `err` at the next CHECK.
- Reset mid-operation: `rst` during SETTLE of a 2-step request → next cycle all outputs 0, FSM in IDLE, no `done`/`err`; a fresh req0 is then accepted and completes normally.
